uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmit FIFO between NREQ requesters (marker source,
//  hex-dump path, future status sources). Each requester offers one 16-bit word:
//  two ASCII bytes, high byte first. The block grants requesters round-robin,

---
 rtl/uart_tx_arbiter_pkg.sv | 11 +
 rtl/uart_tx_arbiter_if.sv | 17 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 78 +++++++
 tb/tb_uart_tx_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_arb_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-FIFO-side signals of the transmit arbiter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]        req;
  logic [WORD_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic                   tx_full;
  logic                   wr_uart;
  logic [BYTE_W-1:0]      w_data;
  logic                   busy;

  modport master (output req, req_data, tx_full, input ack, wr_uart, w_data, busy);
  modport slave  (input req, req_data, tx_full, output ack, wr_uart, w_data, busy);
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: first set req bit after last_grant, wrapping.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);
  always_comb begin : pick
    int cand;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!grant_vld && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant_vld   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding two-byte words from NREQ requesters into the UART TX FIFO.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [NREQ-1:0]   grant;
  logic              grant_vld;
  logic [NREQ-1:0]   ack_nxt;
  logic              load;
  logic              wr;
  logic [BYTE_W-1:0] byte_sel;
  logic [WORD_W-1:0] word_p0;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .req        (bus.req),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  // Grant stage: control state is reset, the latched word is plain data
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NREQ - 1);
      bus.ack    <= '0;
    end else begin
      state   <= state_nxt;
      bus.ack <= ack_nxt;
      if (load) last_grant <= grant_idx;
    end
    if (load) word_p0 <= bus.req_data[int'(grant_idx)*WORD_W +: WORD_W];
  end

  // Send stage: write strobe is masked during reset so a half-sent word is dropped cleanly
  always_comb begin
    state_nxt = state;
    ack_nxt   = '0;
    load      = 1'b0;
    wr        = 1'b0;
    byte_sel  = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = SEND_HI;
          ack_nxt   = grant;
          load      = 1'b1;
        end
      end
      SEND_HI: begin
        byte_sel = word_p0[WORD_W-1 -: BYTE_W];
        wr       = ~bus.tx_full & ~reset;
        if (wr) state_nxt = SEND_LO;
      end
      SEND_LO: begin
        byte_sel = word_p0[BYTE_W-1:0];
        wr       = ~bus.tx_full & ~reset;
        if (wr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.wr_uart = wr;
  assign bus.w_data  = byte_sel;
  assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios followed by random traffic.
module tb_uart_tx_arbiter;
  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus();
  uart_tx_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] byte_q[$];
  logic [7:0] inflight[$];
  logic [7:0] wr_log[$];
  logic [7:0] want[$];
  int         ack_q[$];
  int         ack_log[$];
  int         want_ack[$];

  int              last_g = NREQ - 1;
  logic [NREQ-1:0] pend_ack = '0;
  logic [NREQ-1:0] exp_ack = '0;
  logic [NREQ-1:0] prev_ack = '0;
  logic            exp_wr = 1'b0;
  logic            exp_busy = 1'b0;
  logic [7:0]      exp_wdata = '0;
  logic            in_rst = 1'b1;
  logic            mon_en = 1'b0;
  logic [NREQ-1:0] cur_req = '0;
  logic [15:0]     cur_word[NREQ];

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // One clock of stimulus; the reference model tracks the bytes still owed for the granted word.
  task automatic step(input logic [NREQ-1:0] r, input logic tf, input logic rst_v);
    int g;
    bus.req     = r;
    bus.tx_full = tf;
    reset       = rst_v;
    for (int i = 0; i < NREQ; i++) bus.req_data[16*i +: 16] = cur_word[i];
    exp_ack  = pend_ack;
    pend_ack = '0;
    in_rst   = rst_v;
    if (rst_v) begin
      inflight.delete();
      byte_q.delete();
      ack_q.delete();
      last_g    = NREQ - 1;
      exp_wr    = 1'b0;
      exp_busy  = 1'b0;
      exp_wdata = '0;
    end else if (inflight.size() != 0) begin
      exp_busy  = 1'b1;
      exp_wdata = inflight[0];
      exp_wr    = !tf;
      if (!tf) byte_q.push_back(inflight.pop_front());
    end else begin
      exp_busy  = 1'b0;
      exp_wdata = '0;
      exp_wr    = 1'b0;
      g = rr_pick(r, last_g);
      if (g >= 0) begin
        pend_ack[g] = 1'b1;
        ack_q.push_back(g);
        inflight.push_back(cur_word[g][15:8]);
        inflight.push_back(cur_word[g][7:0]);
        last_g = g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [NREQ-1:0] r, input logic tf, input int n);
    repeat (n) step(r, tf, 1'b0);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    ack_log.delete();
  endtask

  task automatic cmp_logs(input string name);
    chk({name, "_nbytes"}, wr_log.size(), want.size());
    for (int i = 0; i < want.size() && i < wr_log.size(); i++)
      chk({name, "_byte"}, wr_log[i], want[i]);
    chk({name, "_nacks"}, ack_log.size(), want_ack.size());
    for (int i = 0; i < want_ack.size() && i < ack_log.size(); i++)
      chk({name, "_ack"}, ack_log[i], want_ack[i]);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (in_rst) begin
        chk("rst_wr_uart", bus.wr_uart, 0);
        prev_ack = '0;
      end else begin
        int idx;
        chk("wr_uart", bus.wr_uart, exp_wr);
        chk("w_data", bus.w_data, exp_wdata);
        chk("busy", bus.busy, exp_busy);
        chk("ack", bus.ack, exp_ack);
        if (bus.wr_uart) begin
          chk("wr_while_full", bus.tx_full, 0);
          if (byte_q.size() == 0) chk("unexpected_byte", bus.w_data, -1);
          else chk("byte_stream", bus.w_data, byte_q.pop_front());
          wr_log.push_back(bus.w_data);
        end
        if (bus.ack != '0) begin
          chk("ack_onehot", $onehot(bus.ack), 1);
          chk("ack_back_to_back", int'(prev_ack != '0), 0);
          idx = 0;
          for (int i = 0; i < NREQ; i++) if (bus.ack[i]) idx = i;
          if (ack_q.size() == 0) chk("unexpected_ack", idx, -1);
          else chk("ack_order", idx, ack_q.pop_front());
          ack_log.push_back(idx);
        end
        prev_ack = bus.ack;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_full  = 1'b0;
    cur_word[0]  = 16'h5354;
    cur_word[1]  = 16'h3041;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);

    // single request, then idle outputs after the word
    clear_logs();
    run(2'b01, 1'b0, 1);
    run(2'b00, 1'b0, 3);
    want = '{8'h53, 8'h54};
    want_ack = '{0};
    cmp_logs("t1");

    // simultaneous requests after reset, then rotation back to requester 0
    step('0, 1'b0, 1'b1);
    clear_logs();
    run(2'b11, 1'b0, 1);
    run(2'b10, 1'b0, 3);
    run(2'b00, 1'b0, 3);
    run(2'b11, 1'b0, 1);
    run(2'b00, 1'b0, 3);
    want = '{8'h53, 8'h54, 8'h30, 8'h41, 8'h53, 8'h54};
    want_ack = '{0, 1, 0};
    cmp_logs("t2");

    // FIFO full stall during the high byte
    clear_logs();
    run(2'b01, 1'b0, 1);
    run(2'b00, 1'b1, 5);
    run(2'b00, 1'b0, 3);
    want = '{8'h53, 8'h54};
    want_ack = '{0};
    cmp_logs("t3");

    // reset while the low byte is pending
    clear_logs();
    run(2'b01, 1'b0, 1);
    run(2'b00, 1'b0, 1);
    step(2'b00, 1'b0, 1'b1);
    run(2'b00, 1'b0, 2);
    want = '{8'h53};
    want_ack = '{0};
    cmp_logs("t4");

    // continuous request from requester 1
    clear_logs();
    run(2'b10, 1'b0, 12);
    run(2'b00, 1'b0, 3);
    want = '{8'h30, 8'h41, 8'h30, 8'h41, 8'h30, 8'h41, 8'h30, 8'h41};
    want_ack = '{1, 1, 1, 1};
    cmp_logs("t5");

    // random traffic obeying the hold-until-ack rule
    cur_req = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend_ack[i]) begin
          if ($urandom_range(0, 1) == 0) cur_req[i] = 1'b0;
          else cur_word[i] = 16'($urandom);
        end else if (!cur_req[i] && $urandom_range(0, 99) < 40) begin
          cur_req[i]  = 1'b1;
          cur_word[i] = 16'($urandom);
        end
      end
      step(cur_req, ($urandom_range(0, 99) < 30), ($urandom_range(0, 999) == 0));
    end
    run('0, 1'b0, 4);
    chk("drain_bytes", byte_q.size(), 0);
    chk("drain_acks", ack_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
